// File: rtl/svfloat_issue_queue_if.sv
// svfloat_issue_queue_if: request, unit and result signals of the float issue queue.
// master: the side that issues requests, hosts the arithmetic units and consumes results.
// slave:  the issue queue itself.
interface svfloat_issue_queue_if #(
  parameter int unsigned TAG_W = 4
) ();
  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_lhs;
  logic [31:0]      in_rhs;
  logic [TAG_W-1:0] in_tag;
  // Arithmetic unit operands and results
  logic [31:0]      unit_lhs;
  logic [31:0]      unit_rhs;
  logic [31:0]      unit_mul;
  logic [31:0]      unit_div;
  logic [31:0]      unit_add;
  logic [31:0]      unit_sub;
  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [1:0]       out_op;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_lhs, in_rhs, in_tag, out_ready,
    output unit_mul, unit_div, unit_add, unit_sub,
    input  in_ready, unit_lhs, unit_rhs, out_valid, out_result, out_op, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_lhs, in_rhs, in_tag, out_ready,
    input  unit_mul, unit_div, unit_add, unit_sub,
    output in_ready, unit_lhs, unit_rhs, out_valid, out_result, out_op, out_tag, busy
  );
endinterface

// File: rtl/svfloat_issue_queue.sv
// svfloat_issue_queue: issues single-precision operations to external mul/div/add/sub units,
// tracks each request through a fixed-latency shift pipeline and buffers the selected unit
// result, with its op and tag, in an in-order FIFO. Issue credits bound the requests in
// flight so the FIFO can never overflow. Float values are passed through untouched.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - slave modport: request (in_*), unit operands/results (unit_*),
//          result (out_*) and busy
// Parameters: LATENCY (unit latency, 0 = combinational units), DEPTH (FIFO entries and
// credits, power of two >= 2), TAG_W (user tag width).
module svfloat_issue_queue #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input logic                  clk,
  input logic                  rst,
  svfloat_issue_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [31:0]      result;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic                        issue, push, pop, full, empty;
  logic [CntW-1:0]             credits_q, credits_d;
  logic [31:0]                 lhs_q, rhs_q;
  logic [LATENCY:0]            trk_valid_q;
  logic [LATENCY:0][1:0]       trk_op_q;
  logic [LATENCY:0][TAG_W-1:0] trk_tag_q;
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [CntW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]             wr_idx, rd_idx;
  entry_t                      mem_q [DEPTH];
  entry_t                      head;
  logic [31:0]                 cap_result;

  assign wr_idx = wr_ptr_q[PtrW-1:0];
  assign rd_idx = rd_ptr_q[PtrW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);

  assign bus.in_ready = (credits_q != '0);
  assign issue        = bus.in_valid && bus.in_ready;
  // The oldest tracking stage lines up with the unit output of its own operands.
  assign push         = trk_valid_q[LATENCY];
  assign pop          = !empty && bus.out_ready;

  always_comb begin
    cap_result = '0;
    unique case (trk_op_q[LATENCY])
      2'd0: cap_result = bus.unit_mul;
      2'd1: cap_result = bus.unit_div;
      2'd2: cap_result = bus.unit_add;
      2'd3: cap_result = bus.unit_sub;
    endcase
  end

  // A credit is taken on issue and returned on pop; both on one edge cancel out.
  always_comb begin
    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - CntW'(1);
    end else if (pop && !issue) begin
      credits_d = credits_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q   <= CntW'(DEPTH);
      lhs_q       <= '0;
      rhs_q       <= '0;
      trk_valid_q <= '0;
      trk_op_q    <= '0;
      trk_tag_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      credits_q <= credits_d;
      if (issue) begin
        lhs_q <= bus.in_lhs;
        rhs_q <= bus.in_rhs;
      end
      trk_valid_q[0] <= issue;
      trk_op_q[0]    <= bus.in_op;
      trk_tag_q[0]   <= bus.in_tag;
      for (int i = 1; i <= int'(LATENCY); i++) begin
        trk_valid_q[i] <= trk_valid_q[i-1];
        trk_op_q[i]    <= trk_op_q[i-1];
        trk_tag_q[i]   <= trk_tag_q[i-1];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + CntW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + CntW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx] <= '{result: cap_result, op: trk_op_q[LATENCY], tag: trk_tag_q[LATENCY]};
    end
  end

  assign head           = mem_q[rd_idx];
  assign bus.unit_lhs   = lhs_q;
  assign bus.unit_rhs   = rhs_q;
  assign bus.out_valid  = !empty;
  assign bus.out_result = empty ? '0 : head.result;
  assign bus.out_op     = empty ? '0 : head.op;
  assign bus.out_tag    = empty ? '0 : head.tag;
  assign bus.busy       = (|trk_valid_q) || !empty;

  // Credits make this unreachable; a push into a full FIFO without a pop would drop data.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

endmodule

// File: doc/svfloat_issue_queue.md
SVFLOAT_ISSUE_QUEUE -- requirements
Module: svfloat_issue_queue

Interface
REQ-001 Parameter LATENCY, default 1: cycles the arithmetic units take from operand change to valid result; 0 means combinational units.
REQ-002 Parameter DEPTH, default 4: result buffer entries and issue credits; must be a power of two and at least 2.
REQ-003 Parameter TAG_W, default 4: width of the user tag.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  request accepted when in_valid is also high.
REQ-008 in_op  input  2  operation: 0 mul, 1 div, 2 add, 3 sub.
REQ-009 in_lhs, in_rhs  input  32 each  IEEE-754 single-precision operands.
REQ-010 in_tag  input  TAG_W  user tag, returned with the result.
REQ-011 unit_lhs, unit_rhs  output  32 each  operands driven to the svfloat mul/div/add/sub units.
REQ-012 unit_mul, unit_div, unit_add, unit_sub  input  32 each  unit results.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  result consumed when out_valid is also high.
REQ-015 out_result  output  32  result; out_op (2) and out_tag (TAG_W) carry the matching request's values.
REQ-016 busy  output  1  high when any operation is in flight or buffered.

Function
REQ-017 Issue: in_valid && in_ready at edge E0 registers in_lhs/in_rhs onto unit_lhs/unit_rhs; both hold their last value when no issue occurs.
REQ-018 Tracking: a shift pipeline of LATENCY+1 stages carries {valid, op, tag}, advancing every cycle unconditionally.
REQ-019 Capture: at edge E(LATENCY+1) the unit output selected by the tracked op is pushed into the result FIFO with its op and tag; minimum issue-to-out_valid is LATENCY+1 cycles.
REQ-020 Credits: counter initialised to DEPTH; decrement on issue, increment on pop, unchanged when both occur on the same edge; never exceeds DEPTH or drops below 0.
REQ-021 in_ready = (credits != 0); combinationally independent of in_valid and out_ready.
REQ-022 FIFO: DEPTH entries, in-order, wrap-around pointers; pop on out_valid && out_ready; push and pop on the same edge are legal, including when full.
REQ-023 The credit scheme guarantees a push never hits a full FIFO; an assertion flags any push to a full FIFO.
REQ-024 out_valid = FIFO not empty; out_result, out_op and out_tag are stable while out_valid && !out_ready.
REQ-025 out_result, out_op and out_tag drive 0 while out_valid is low.
REQ-026 Throughput: one issue per cycle sustained indefinitely when out_ready is held high and DEPTH >= LATENCY+2.
REQ-027 busy = any tracking-stage valid || FIFO not empty.
REQ-028 The block does not inspect or modify float values (NaN, inf and denormals pass through unchanged).

Reset
REQ-029 rst high immediately clears the credits to DEPTH, the tracking valids and the FIFO pointers, and drives unit_lhs/unit_rhs to 0, out_valid to 0 and busy to 0.
REQ-030 in_ready is 1 during and after reset.
REQ-031 Reset mid-operation discards every in-flight and buffered result; none appears after reset releases.
REQ-032 The first issue is accepted on the first rising edge after rst falls.

Verification (LATENCY=1, DEPTH=4 unless noted)
REQ-033 Issue add 0x3F800000 + 0x40000000, tag 1, at E0 with out_ready=1 -> out_valid high after E2; out_result 0x40400000, out_op 2, out_tag 1; popped at E3.
REQ-034 Issue div 0x3F800000 / 0x00000000, tag 5 -> out_result 0x7F800000, out_op 1, out_tag 5.
REQ-035 out_ready=0, issue 5 back-to-back requests tagged 0..4 -> in_ready falls after the 4th; the 5th is held; raising out_ready delivers tags 0..4 in order, results matching.
REQ-036 Credits at 0, pulse out_ready for exactly 1 cycle -> in_ready returns high for one cycle, exactly one more request is accepted, and in_ready falls again.
REQ-037 out_ready=1, 16 back-to-back mixed ops -> in_ready stays 1 throughout; 16 results on consecutive cycles starting 2 cycles after the first issue.
REQ-038 Assert rst with 2 ops in flight and 1 buffered -> out_valid=0 and busy=0 immediately; after release, no stale result and in_ready=1.
